// File: rtl/song_sequencer_pkg.sv
// Shared encodings for the song sequencer: word layout, play modes and the
// gate-length rule used by every voice timer.
package song_sequencer_pkg;

  localparam int MODE_W    = 2;
  localparam int TONE_W    = 6;
  localparam int DUR_W     = 4;
  localparam int VOICE_LSB = 4;

  localparam logic [MODE_W-1:0] MODE_NORMAL   = 2'b00;
  localparam logic [MODE_W-1:0] MODE_STACCATO = 2'b01;
  localparam logic [MODE_W-1:0] MODE_SLURRED  = 2'b10;
  localparam logic [MODE_W-1:0] MODE_BPM_COMM = 2'b11;

  localparam logic [7:0] END_TEMPO = 8'h00;

  // [15:14] mode, [13:8] tone, [7:0] voice/duration or tempo
  typedef struct packed {
    logic [MODE_W-1:0] mode;
    logic [TONE_W-1:0] tone;
    logic [7:0]        low;
  } song_word_t;

  function automatic logic is_end_word(input song_word_t w);
    return (w.mode == MODE_BPM_COMM) && (w.low == END_TEMPO);
  endfunction

  // ceil(D/2) written as D - floor(D/2) to stay within DUR_W bits
  function automatic logic [DUR_W-1:0] gate_len(input logic [MODE_W-1:0] mode,
                                                input logic [DUR_W-1:0]  dur);
    case (mode)
      MODE_NORMAL:   gate_len = (dur > 4'd1) ? dur - 4'd1 : 4'd1;
      MODE_STACCATO: gate_len = dur - (dur >> 1);
      default:       gate_len = dur;
    endcase
  endfunction

endpackage

// File: rtl/seq_voice.sv
// One voice timer: gate phase then optional gap phase, both counted in ticks
// and frozen while playback is paused.
//   state    | meaning
//   ST_IDLE  | free, can accept a note
//   ST_GATE  | sounding, cnt = gate ticks left
//   ST_GAP   | silent remainder of the note, cnt = gap ticks left
module seq_voice
  import song_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [MODE_W-1:0] load_mode,
  input  logic [TONE_W-1:0] load_tone,
  input  logic [DUR_W-1:0]  load_dur,
  input  logic              tick,
  input  logic              playing,
  output logic              busy,
  output logic              gate,
  output logic [TONE_W-1:0] tone
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GATE = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]       state;
  logic [DUR_W-1:0] cnt;
  logic [DUR_W-1:0] gap_len;
  logic [DUR_W-1:0] g_len;

  assign g_len = gate_len(load_mode, load_dur);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      gap_len <= '0;
      tone    <= '0;
    end else if (clear) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      gap_len <= '0;
    end else if (load) begin
      state   <= ST_GATE;
      cnt     <= g_len;
      gap_len <= load_dur - g_len;
      tone    <= load_tone;
    end else if (tick && playing) begin
      case (state)
        ST_GATE: begin
          if (cnt == DUR_W'(1)) begin
            if (gap_len == '0) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_GAP;
              cnt   <= gap_len;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == DUR_W'(1)) state <= ST_IDLE;
          else                  cnt   <= cnt - 1'b1;
        end
        ST_IDLE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign gate = (state == ST_GATE) && playing;

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: prefetches song words into a small FIFO, dispatches notes
// to voice timers in order, and handles tempo, end-of-song and restart.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 23,
  parameter int DEFAULT_BPM = 80
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    play_btn,
  input  logic                    restart,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_ack,
  input  logic [15:0]             mem_data,
  output logic                    playing,
  output logic [7:0]              bpm,
  output logic [6*CHANNELS-1:0]   ch_tone,
  output logic [CHANNELS-1:0]     ch_gate,
  output logic                    song_end
);

  localparam int         PTR_W   = $clog2(DEPTH);
  localparam int         VOICE_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [7:0] BPM_RST = 8'(DEFAULT_BPM);

  logic [15:0]      fifo_mem [DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr, fifo_cnt;
  logic             fifo_full, fifo_empty;
  logic             push, pop, flush;
  song_word_t       head;

  logic             discard_q, end_buf, ack_ok, btn_q, btn_rise;
  logic             bpm_load, end_done;

  logic [CHANNELS-1:0] voice_busy, load_vec, sel_onehot;
  logic [VOICE_W-1:0]  voice_sel;
  logic                sel_hit, sel_busy;

  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign fifo_full  = (fifo_cnt == (PTR_W+1)'(DEPTH));
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];

  assign flush  = restart || end_done;
  assign ack_ok = mem_ack && mem_req;
  assign push   = ack_ok && !discard_q && !flush;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= mem_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A request in flight across a flush stays up until acked, but its word is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      discard_q <= 1'b0;
      end_buf   <= 1'b0;
    end else if (flush) begin
      mem_addr  <= '0;
      end_buf   <= 1'b0;
      mem_req   <= mem_req && !mem_ack;
      discard_q <= mem_req && !mem_ack;
    end else if (ack_ok) begin
      mem_req   <= 1'b0;
      discard_q <= 1'b0;
      if (!discard_q) begin
        mem_addr <= mem_addr + 1'b1;
        if (is_end_word(song_word_t'(mem_data))) end_buf <= 1'b1;
      end
    end else if (!mem_req && !fifo_full && !end_buf) begin
      mem_req <= 1'b1;
    end
  end

  assign voice_sel = (CHANNELS > 1) ? head.low[VOICE_LSB +: VOICE_W] : '0;

  always_comb begin
    sel_hit    = 1'b0;
    sel_busy   = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (voice_sel == VOICE_W'(i)) begin
        sel_hit       = 1'b1;
        sel_busy      = voice_busy[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Head-of-line dispatch; a busy target voice stalls everything behind it.
  always_comb begin
    pop      = 1'b0;
    load_vec = '0;
    bpm_load = 1'b0;
    end_done = 1'b0;
    if (playing && !fifo_empty && !restart) begin
      if (head.mode == MODE_BPM_COMM) begin
        if (head.low != END_TEMPO) begin
          pop      = 1'b1;
          bpm_load = 1'b1;
        end else if (voice_busy == '0) begin
          end_done = 1'b1;
        end
      end else if (head.low[DUR_W-1:0] == '0 || !sel_hit) begin
        pop = 1'b1;
      end else if (!sel_busy) begin
        pop      = 1'b1;
        load_vec = sel_onehot;
      end
    end
  end

  assign btn_rise = play_btn && !btn_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q    <= 1'b0;
      playing  <= 1'b0;
      bpm      <= BPM_RST;
      song_end <= 1'b0;
    end else begin
      btn_q    <= play_btn;
      song_end <= end_done;
      if (end_done)      playing <= 1'b0;
      else if (btn_rise) playing <= !playing;
      if (flush)         bpm <= BPM_RST;
      else if (bpm_load) bpm <= head.low;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_voice
    seq_voice u_voice (
      .clk       (clk),
      .rst       (rst),
      .clear     (restart),
      .load      (load_vec[i]),
      .load_mode (head.mode),
      .load_tone (head.tone),
      .load_dur  (head.low[DUR_W-1:0]),
      .tick      (tick),
      .playing   (playing),
      .busy      (voice_busy[i]),
      .gate      (ch_gate[i]),
      .tone      (ch_tone[6*i +: 6])
    );
  end

endmodule
